// File: rtl/payment_arb_pkg.sv
// Shared types and helpers for the payment lane arbiter.
// Build option: PAYMENT_ARB_PRIORITY_LANE0_EN (lane 0 express priority).
package payment_arb_pkg;

  localparam int DEF_N_LANES     = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;
  localparam int MAX_LANES       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_ACTIVE,
    ST_RELEASE
  } arb_state_t;

  // Callers guarantee at most one bit set; OR-ing indices keeps it mux-free.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_LANES-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/payment_lane_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after rr_ptr,
// with optional unconditional priority for lane 0.
module rr_pick
  import payment_arb_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int ID_W    = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               prio0_en,
  output logic [N_LANES-1:0] pick,
  output logic [ID_W-1:0]    pick_idx,
  output logic               valid
);

  logic [2*N_LANES-1:0] rot_dbl;
  logic [2*N_LANES-1:0] back_dbl;
  logic [N_LANES-1:0]   rot;
  logic [N_LANES-1:0]   rot_pick;

  always_comb begin
    // Rotate so rr_ptr sits at bit 0, isolate lowest set bit, rotate back.
    rot_dbl  = {req, req} >> rr_ptr;
    rot      = rot_dbl[N_LANES-1:0];
    rot_pick = rot & (-rot);
    back_dbl = {rot_pick, rot_pick} << rr_ptr;
    pick     = back_dbl[2*N_LANES-1:N_LANES];
    if (prio0_en && req[0]) begin
      pick = {{(N_LANES-1){1'b0}}, 1'b1};
    end
    valid    = |req;
    pick_idx = ID_W'(onehot_to_idx(MAX_LANES'(pick)));
  end

endmodule

// File: rtl/payment_lane_arbiter.sv
// Shares one payment controller among N_LANES checkout lanes with a watchdog.
// Build option: PAYMENT_ARB_PRIORITY_LANE0_EN gives lane 0 absolute priority.
module payment_lane_arbiter
  import payment_arb_pkg::*;
#(
  parameter int N_LANES     = DEF_N_LANES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int ID_W        = $clog2(N_LANES),
  parameter int CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_LANES-1:0] lane_req,
  input  logic [N_LANES-1:0] lane_cancel,
  output logic [N_LANES-1:0] lane_grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               proc_init,
  output logic               proc_reset,
  input  logic               proc_light,
  input  logic               proc_abort,
  output logic [N_LANES-1:0] lane_done,
  output logic [N_LANES-1:0] lane_fail,
  output logic               timeout
);

`ifdef PAYMENT_ARB_PRIORITY_LANE0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  arb_state_t         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               abort_seen_q, abort_seen_d;
  logic [N_LANES-1:0] lane_grant_q, lane_grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               proc_init_q, proc_init_d;
  logic               proc_reset_q, proc_reset_d;
  logic [N_LANES-1:0] lane_done_q, lane_done_d;
  logic [N_LANES-1:0] lane_fail_q, lane_fail_d;
  logic               timeout_q, timeout_d;

  logic [N_LANES-1:0] pick;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_valid;
  logic [CNT_W-1:0]   cnt_inc;
  logic               timeout_hit;

  rr_pick #(
    .N_LANES (N_LANES),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req      (lane_req & ~lane_cancel),
    .rr_ptr   (rr_ptr_q),
    .prio0_en (PRIO0),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_valid)
  );

  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    abort_seen_d = abort_seen_q;
    lane_grant_d = lane_grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = busy_q;
    proc_init_d  = 1'b0;
    proc_reset_d = 1'b0;
    lane_done_d  = '0;
    lane_fail_d  = '0;
    timeout_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          lane_grant_d = pick;
          grant_id_d   = pick_idx;
          busy_d       = 1'b1;
          state_d      = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Last chance for the lane to back out before the controller starts.
        if (((lane_cancel & lane_grant_q) != '0) || ((lane_req & lane_grant_q) == '0)) begin
          lane_fail_d = lane_grant_q;
          state_d     = ST_RELEASE;
        end else begin
          proc_init_d = 1'b1;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (proc_light) begin
          state_d = ST_ACTIVE;
        end else if (timeout_hit) begin
          timeout_d    = 1'b1;
          proc_reset_d = 1'b1;
          lane_fail_d  = lane_grant_q;
          state_d      = ST_RELEASE;
        end
      end
      ST_ACTIVE: begin
        cnt_d        = cnt_inc;
        abort_seen_d = abort_seen_q | proc_abort;
        // A falling light on the expiry cycle still counts as a normal finish.
        if (!proc_light) begin
          if (abort_seen_d) lane_fail_d = lane_grant_q;
          else              lane_done_d = lane_grant_q;
          state_d = ST_RELEASE;
        end else if (timeout_hit) begin
          timeout_d    = 1'b1;
          proc_reset_d = 1'b1;
          lane_fail_d  = lane_grant_q;
          state_d      = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        lane_grant_d = '0;
        busy_d       = 1'b0;
        abort_seen_d = 1'b0;
        if (!PRIO0 || (grant_id_q != '0)) begin
          rr_ptr_d = (grant_id_q == ID_W'(N_LANES - 1)) ? '0 : grant_id_q + ID_W'(1);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      abort_seen_q <= 1'b0;
      lane_grant_q <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      proc_init_q  <= 1'b0;
      proc_reset_q <= 1'b0;
      lane_done_q  <= '0;
      lane_fail_q  <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      abort_seen_q <= abort_seen_d;
      lane_grant_q <= lane_grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      proc_init_q  <= proc_init_d;
      proc_reset_q <= proc_reset_d;
      lane_done_q  <= lane_done_d;
      lane_fail_q  <= lane_fail_d;
      timeout_q    <= timeout_d;
    end
  end

  assign lane_grant = lane_grant_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign proc_init  = proc_init_q;
  assign proc_reset = proc_reset_q;
  assign lane_done  = lane_done_q;
  assign lane_fail  = lane_fail_q;
  assign timeout    = timeout_q;

endmodule
